// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V 16-bit pipeline: widths, ALU opcodes and
// the execute-stage FSM state type.
package misc_v_pkg;

    localparam int WIDTH      = 16;
    localparam int MUL_CYCLES = WIDTH;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_MUL = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, one multiplier bit per step, producing the low
// WIDTH bits of the product. o_result is valid as the final product on o_done.
module seq_multiplier #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_partial;

    // o_result includes the current step's partial product so the last step
    // can be delivered without an extra cycle.
    assign w_partial = r_b[r_cnt] ? (r_a << r_cnt) : '0;
    assign o_result  = r_acc + w_partial;
    assign o_done    = (r_cnt == CNT_W'(MUL_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= o_result;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU, iterative multiply and the
// EX/MEM pipeline register. Stall holds ID/EX while a multiply is running.
module ex_mem_stage #(
    parameter int WIDTH      = misc_v_pkg::WIDTH,
    parameter int MUL_CYCLES = misc_v_pkg::MUL_CYCLES
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IRegWrite,
    input  logic             IMemWrite,
    input  logic             IMemRead,
    input  logic             IRegStore,
    input  logic             IALUSrc,
    input  logic [2:0]       IALUOP,
    input  logic [WIDTH-1:0] IPCP2,
    input  logic [WIDTH-1:0] I1stArg,
    input  logic [WIDTH-1:0] I2ndArg,
    input  logic [WIDTH-1:0] I3rdArg,
    input  logic [WIDTH-1:0] IImm,
    input  logic [WIDTH-1:0] IRs1,
    input  logic [WIDTH-1:0] IRs2,
    input  logic [WIDTH-1:0] IRd,
    input  logic             MemFwdRegWrite,
    input  logic [WIDTH-1:0] MemFwdRd,
    input  logic [WIDTH-1:0] MemFwdData,
    input  logic             WbFwdRegWrite,
    input  logic [WIDTH-1:0] WbFwdRd,
    input  logic [WIDTH-1:0] WbFwdData,
    input  logic             Flush,
    output logic             Stall,
    output logic             ORegWrite,
    output logic             OMemWrite,
    output logic             OMemRead,
    output logic             ORegStore,
    output logic [WIDTH-1:0] OPCP2,
    output logic [WIDTH-1:0] OALUResult,
    output logic [WIDTH-1:0] OStoreData,
    output logic [WIDTH-1:0] ORd,
    output logic             OZero
);

    import misc_v_pkg::*;

    function automatic logic [WIDTH-1:0] fwd(
        input logic [WIDTH-1:0] idx,
        input logic [WIDTH-1:0] val,
        input logic             mem_we,
        input logic [WIDTH-1:0] mem_rd,
        input logic [WIDTH-1:0] mem_data,
        input logic             wb_we,
        input logic [WIDTH-1:0] wb_rd,
        input logic [WIDTH-1:0] wb_data
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == idx))
            return mem_data;
        else if (wb_we && (wb_rd != '0) && (wb_rd == idx))
            return wb_data;
        else
            return val;
    endfunction

    function automatic logic [WIDTH-1:0] alu(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[3:0];
            ALU_SRL: return a >> b[3:0];
            default: return '0;
        endcase
    endfunction

    ex_state_t        r_state;
    ex_state_t        w_next;
    logic             w_start;
    logic             w_step;
    logic             w_stall;
    logic             w_load_new;
    logic             w_load_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH-1:0] w_alu;

    logic             r_cap_rw, r_cap_mw, r_cap_mr, r_cap_rs;
    logic [WIDTH-1:0] r_cap_pcp2, r_cap_sd, r_cap_rd;

    logic             r_rw, r_mw, r_mr, r_rs, r_zero;
    logic [WIDTH-1:0] r_pcp2, r_res, r_sd, r_rd;

    always_comb begin
        w_a   = fwd(IRs1, I1stArg, MemFwdRegWrite, MemFwdRd, MemFwdData,
                    WbFwdRegWrite, WbFwdRd, WbFwdData);
        w_b   = fwd(IRs2, I2ndArg, MemFwdRegWrite, MemFwdRd, MemFwdData,
                    WbFwdRegWrite, WbFwdRd, WbFwdData);
        w_s   = fwd(IRd, I3rdArg, MemFwdRegWrite, MemFwdRd, MemFwdData,
                    WbFwdRegWrite, WbFwdRd, WbFwdData);
        w_bop = IALUSrc ? IImm : w_b;
        w_alu = alu(IALUOP, w_a, w_bop);
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_step     = 1'b0;
        w_stall    = 1'b0;
        w_load_new = 1'b0;
        w_load_mul = 1'b0;
        if (Flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IALUOP == ALU_MUL) begin
                        w_start = 1'b1;
                        w_stall = 1'b1;
                        w_next  = MUL;
                    end else begin
                        w_load_new = 1'b1;
                    end
                end
                MUL: begin
                    w_step = 1'b1;
                    if (w_mul_done) begin
                        w_load_mul = 1'b1;
                        w_next     = IDLE;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Gate with Reset so ID/EX is never frozen while the stage is in reset.
    assign Stall = w_stall & ~Reset;

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .i_clk    (CLK),
        .i_rst    (Reset),
        .i_start  (w_start),
        .i_abort  (Flush),
        .i_step   (w_step),
        .i_a      (w_a),
        .i_b      (w_bop),
        .o_done   (w_mul_done),
        .o_result (w_mul_res)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cap_rw   <= 1'b0;
            r_cap_mw   <= 1'b0;
            r_cap_mr   <= 1'b0;
            r_cap_rs   <= 1'b0;
            r_cap_pcp2 <= '0;
            r_cap_sd   <= '0;
            r_cap_rd   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cap_rw   <= IRegWrite;
                r_cap_mw   <= IMemWrite;
                r_cap_mr   <= IMemRead;
                r_cap_rs   <= IRegStore;
                r_cap_pcp2 <= IPCP2;
                r_cap_sd   <= w_s;
                r_cap_rd   <= IRd;
            end
        end
    end

    // EX/MEM register: anything that is not a completed instruction is a bubble.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_rw   <= 1'b0;
            r_mw   <= 1'b0;
            r_mr   <= 1'b0;
            r_rs   <= 1'b0;
            r_zero <= 1'b0;
            r_pcp2 <= '0;
            r_res  <= '0;
            r_sd   <= '0;
            r_rd   <= '0;
        end else if (w_load_new) begin
            r_rw   <= IRegWrite;
            r_mw   <= IMemWrite;
            r_mr   <= IMemRead;
            r_rs   <= IRegStore;
            r_zero <= (w_alu == '0);
            r_pcp2 <= IPCP2;
            r_res  <= w_alu;
            r_sd   <= w_s;
            r_rd   <= IRd;
        end else if (w_load_mul) begin
            r_rw   <= r_cap_rw;
            r_mw   <= r_cap_mw;
            r_mr   <= r_cap_mr;
            r_rs   <= r_cap_rs;
            r_zero <= (w_mul_res == '0);
            r_pcp2 <= r_cap_pcp2;
            r_res  <= w_mul_res;
            r_sd   <= r_cap_sd;
            r_rd   <= r_cap_rd;
        end else begin
            r_rw   <= 1'b0;
            r_mw   <= 1'b0;
            r_mr   <= 1'b0;
            r_rs   <= 1'b0;
            r_zero <= 1'b0;
            r_pcp2 <= '0;
            r_res  <= '0;
            r_sd   <= '0;
            r_rd   <= '0;
        end
    end

    assign ORegWrite  = r_rw;
    assign OMemWrite  = r_mw;
    assign OMemRead   = r_mr;
    assign ORegStore  = r_rs;
    assign OZero      = r_zero;
    assign OPCP2      = r_pcp2;
    assign OALUResult = r_res;
    assign OStoreData = r_sd;
    assign ORd        = r_rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: the driver queues the expected
// EX/MEM contents for every edge and a monitor compares them after the edge.
module tb_ex_mem_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IRegWrite, IMemWrite, IMemRead, IRegStore, IALUSrc;
    logic [2:0]  IALUOP;
    logic [15:0] IPCP2, I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd;
    logic        MemFwdRegWrite, WbFwdRegWrite, Flush;
    logic [15:0] MemFwdRd, MemFwdData, WbFwdRd, WbFwdData;
    logic        Stall;
    logic        ORegWrite, OMemWrite, OMemRead, ORegStore, OZero;
    logic [15:0] OPCP2, OALUResult, OStoreData, ORd;

    ex_mem_stage dut (
        .CLK(CLK), .Reset(Reset),
        .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
        .IRegStore(IRegStore), .IALUSrc(IALUSrc), .IALUOP(IALUOP),
        .IPCP2(IPCP2), .I1stArg(I1stArg), .I2ndArg(I2ndArg), .I3rdArg(I3rdArg),
        .IImm(IImm), .IRs1(IRs1), .IRs2(IRs2), .IRd(IRd),
        .MemFwdRegWrite(MemFwdRegWrite), .MemFwdRd(MemFwdRd), .MemFwdData(MemFwdData),
        .WbFwdRegWrite(WbFwdRegWrite), .WbFwdRd(WbFwdRd), .WbFwdData(WbFwdData),
        .Flush(Flush), .Stall(Stall),
        .ORegWrite(ORegWrite), .OMemWrite(OMemWrite), .OMemRead(OMemRead),
        .ORegStore(ORegStore), .OPCP2(OPCP2), .OALUResult(OALUResult),
        .OStoreData(OStoreData), .ORd(ORd), .OZero(OZero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [68:0] v;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    localparam logic [68:0] BUB = '0;

    // Layout: {RegWrite, MemWrite, MemRead, RegStore, Zero, PCP2, Result, StoreData, Rd}
    function automatic logic [68:0] mk(input logic rw, mw, mr, rs,
                                       input logic [15:0] pcp2, res, sd, rd);
        return {rw, mw, mr, rs, (res == 16'h0000), pcp2, res, sd, rd};
    endfunction

    task automatic chk(input string nm, input logic [68:0] got, input logic [68:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: one queued expectation per edge, compared just after that edge.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            chk($sformatf("out tag=%0d", m_e.tag),
                {ORegWrite, OMemWrite, OMemRead, ORegStore, OZero,
                 OPCP2, OALUResult, OStoreData, ORd}, m_e.v);
        end
    end

    task automatic cyc(input logic [68:0] v, input logic st);
        #1;
        chk($sformatf("stall tag=%0d", tag), {68'b0, Stall}, {68'b0, st});
        exp_q.push_back('{v: v, tag: tag});
        tag++;
        @(posedge CLK);
        #2;
    endtask

    task automatic setop(input logic [2:0] op, input logic [15:0] a, b, s, imm,
                         input logic alusrc, input logic [15:0] rd);
        IALUOP = op; I1stArg = a; I2ndArg = b; I3rdArg = s; IImm = imm;
        IALUSrc = alusrc; IRd = rd; IRs1 = 16'd0; IRs2 = 16'd0;
        IRegWrite = 1'b1; IMemWrite = 1'b0; IMemRead = 1'b0; IRegStore = 1'b0;
    endtask

    task automatic mul_run(input logic [15:0] a, b, res);
        setop(3'd7, a, b, 16'h0000, 16'h0000, 1'b0, 16'd9);
        for (int i = 0; i < 16; i++) cyc(BUB, 1'b1);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, IPCP2, res, 16'h0000, 16'd9), 1'b0);
    endtask

    task automatic reset_pulse(input string nm);
        Reset = 1'b1;
        #1;
        chk({nm, " outputs"}, {ORegWrite, OMemWrite, OMemRead, ORegStore, OZero,
                               OPCP2, OALUResult, OStoreData, ORd}, BUB);
        chk({nm, " stall"}, {68'b0, Stall}, 69'b0);
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Flush = 1'b0; IPCP2 = 16'h0010;
        MemFwdRegWrite = 1'b0; MemFwdRd = 16'd0; MemFwdData = 16'h0000;
        WbFwdRegWrite = 1'b0; WbFwdRd = 16'd0; WbFwdData = 16'h0000;
        setop(3'd7, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'd1);
        #2;
        chk("reset outputs", {ORegWrite, OMemWrite, OMemRead, ORegStore, OZero,
                              OPCP2, OALUResult, OStoreData, ORd}, BUB);
        chk("reset stall", {68'b0, Stall}, 69'b0);
        @(posedge CLK);
        #3;
        Reset = 1'b0;

        setop(3'd0, 16'h0003, 16'h0004, 16'h0ABC, 16'h0000, 1'b0, 16'd5);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0007, 16'h0ABC, 16'd5), 1'b0);
        reset_pulse("async reset");

        setop(3'd0, 16'h0100, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'd5);
        IRs1 = 16'd2;
        MemFwdRegWrite = 1'b1; MemFwdRd = 16'd2; MemFwdData = 16'h0010;
        WbFwdRegWrite = 1'b1; WbFwdRd = 16'd2; WbFwdData = 16'h0020;
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0011, 16'h0000, 16'd5), 1'b0);
        MemFwdRegWrite = 1'b0;
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0021, 16'h0000, 16'd5), 1'b0);
        MemFwdRegWrite = 1'b1; IRs1 = 16'd0;
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0101, 16'h0000, 16'd5), 1'b0);

        setop(3'd0, 16'h0001, 16'h0001, 16'h5555, 16'h0000, 1'b0, 16'd2);
        IRegWrite = 1'b0; IMemWrite = 1'b1; IRs1 = 16'd3; IRs2 = 16'd4;
        cyc(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0002, 16'h0010, 16'd2), 1'b0);
        MemFwdRegWrite = 1'b0;

        setop(3'd0, 16'h0005, 16'h0999, 16'h0000, 16'h0000, 1'b0, 16'd6);
        IRs2 = 16'd4; WbFwdRd = 16'd4; WbFwdData = 16'h0007;
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h000C, 16'h0000, 16'd6), 1'b0);
        WbFwdRegWrite = 1'b0;

        setop(3'd1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'd1);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'd1), 1'b0);
        setop(3'd2, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 1'b0, 16'd1);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hF000, 16'h0000, 16'd1), 1'b0);
        setop(3'd3, 16'hF0F0, 16'h0F00, 16'h0000, 16'h0000, 1'b0, 16'd1);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hFFF0, 16'h0000, 16'd1), 1'b0);
        setop(3'd4, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 16'd1);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hFF00, 16'h0000, 16'd1), 1'b0);
        setop(3'd5, 16'h0001, 16'h0003, 16'h0000, 16'h0014, 1'b1, 16'd3);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0010, 16'h0000, 16'd3), 1'b0);

        // MUL with A forwarded from MEM; later input changes must be ignored.
        IPCP2 = 16'h0200;
        setop(3'd7, 16'hDEAD, 16'h0045, 16'h0033, 16'h0000, 1'b0, 16'd7);
        IRs1 = 16'd3; MemFwdRegWrite = 1'b1; MemFwdRd = 16'd3; MemFwdData = 16'h0123;
        for (int i = 0; i < 16; i++) begin
            cyc(BUB, 1'b1);
            if (i == 0) begin
                MemFwdData = 16'hFFFF; I2ndArg = 16'h0001; IPCP2 = 16'h0300;
            end
        end
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h4E6F, 16'h0033, 16'd7), 1'b0);
        MemFwdRegWrite = 1'b0; IPCP2 = 16'h0204;
        setop(3'd0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'd8);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0204, 16'h0002, 16'h0000, 16'd8), 1'b0);

        mul_run(16'hFFFF, 16'hFFFF, 16'h0001);
        mul_run(16'h8000, 16'h0002, 16'h0000);

        // Flush when the multiplier count reaches 7.
        setop(3'd7, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'd4);
        for (int i = 0; i < 8; i++) cyc(BUB, 1'b1);
        Flush = 1'b1;
        cyc(BUB, 1'b0);
        Flush = 1'b0;
        setop(3'd0, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16'd4);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0204, 16'h0005, 16'h0000, 16'd4), 1'b0);

        // Asynchronous reset in the middle of a multiply.
        setop(3'd7, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'd4);
        for (int i = 0; i < 6; i++) cyc(BUB, 1'b1);
        reset_pulse("mid-mul reset");
        setop(3'd6, 16'h8000, 16'h0003, 16'h0000, 16'h000F, 1'b1, 16'd2);
        cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0204, 16'h0001, 16'h0000, 16'd2), 1'b0);

        @(posedge CLK);
        #3;
        chk("queue drained", 69'(exp_q.size()), 69'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register of the 16-bit MISC-V pipeline. It consumes the ID/EX register outputs and forwards operands from the MEM and WB stages. It computes the ALU result and registers the result and control bits for the memory stage. MUL is iterative and multi-cycle, and the block drives Stall back to the ID/EX register's write enable (ID/EX RegWrite = ~Stall).

Parameters:
WIDTH, 16, datapath and register-index width
MUL_CYCLES, 16, iterative multiply steps (one per multiplier bit; equals WIDTH)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
IRegWrite, IMemWrite, IMemRead, IRegStore, IALUSrc  in  1 each  control bits from ID/EX
IALUOP  in  3  ALU operation
IPCP2, I1stArg, I2ndArg, I3rdArg, IImm  in  WIDTH each  PC+2, rs1 value, rs2 value, store/third value, immediate
IRs1, IRs2, IRd  in  WIDTH each  register indices
MemFwdRegWrite  in  1  MEM-stage instruction writes a register
MemFwdRd, MemFwdData  in  WIDTH each  MEM-stage destination index and value
WbFwdRegWrite  in  1  WB-stage instruction writes a register
WbFwdRd, WbFwdData  in  WIDTH each  WB-stage destination index and value
Flush  in  1  squash the instruction in EX (branch redirect)
Stall  out  1  combinational; hold ID/EX
ORegWrite, OMemWrite, OMemRead, ORegStore  out  1 each  registered controls to MEM
OPCP2, OALUResult, OStoreData, ORd  out  WIDTH each  registered values to MEM
OZero  out  1  registered; OALUResult == 0

Behaviour:
- Reset (async, active-high): all O* outputs go to 0 and the FSM goes to IDLE. Counter, accumulator and captured operands clear. Stall is 0 during reset.
- Forwarding applies to three operands: A from I1stArg/IRs1, B from I2ndArg/IRs2, S from I3rdArg/IRd.
  - MEM source: used when MemFwdRegWrite=1, MemFwdRd!=0 and MemFwdRd equals the operand's index.
  - WB source: used under the same rule with the Wb* signals.
  - MEM wins over WB. Otherwise the ID/EX value is used. Index 0 is never forwarded.
- Second ALU input: Bop = IALUSrc ? IImm : B. Store data = S.
- ALUOP encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL by Bop[3:0], 6 SRL (logical) by Bop[3:0], 7 MUL (low 16 bits of the product). All arithmetic is modulo 2^16.
- Single-cycle ops (FSM in IDLE, ALUOP 0-6, Flush=0): 1-cycle latency. The next rising edge loads the controls, OPCP2, ORd=IRd, OALUResult, OStoreData and OZero. Stall=0.
- FSM states: IDLE, MUL.
  - IDLE with IALUOP=7 and Flush=0:
    - Stall=1.
    - Capture A, Bop, S, IPCP2, IRd and all control bits.
    - acc=0, cnt=0, go to MUL.
    - EX/MEM loads a bubble (all O* = 0).
  - MUL, each cycle:
    - If Bcap[cnt]=1, add (Acap << cnt) to acc; then cnt++.
    - ID/EX inputs are ignored in this state.
  - MUL, cnt<15: Stall=1; EX/MEM loads a bubble.
  - MUL, cnt==15:
    - Stall=0.
    - EX/MEM loads the captured controls and OALUResult = acc + (Bcap[15] ? Acap<<15 : 0).
    - Go to IDLE.
  - Total: MUL occupies EX for 17 cycles; its result appears at the MEM stage 17 edges after it entered EX.
- Forwarded values are sampled once, at MUL capture. Later changes on Mem*/Wb* during MUL have no effect.
- Flush=1 has priority in any state:
  - EX/MEM loads a bubble at the next edge; FSM goes to IDLE; Stall=0.
  - A MUL in progress is aborted and produces no result.
- Reset asserted mid-MUL: immediate return to IDLE with outputs 0. No partial result ever reaches MEM.
- A bubble in ID/EX (all controls 0, ALUOP 0) passes through as a bubble.

Decomposition:
- Shared package misc_v_pkg holds:
  - WIDTH = 16
  - ALUOP encodings: ALU_ADD..ALU_MUL
  - MUL_CYCLES
  - FSM state typedef ex_state_t {IDLE, MUL}
- One sub-module, seq_multiplier, contains the cnt/acc/captured-operand datapath, the start/abort inputs and the done output. Forwarding muxes, ALU and EX/MEM register stay in ex_mem_stage.

Test Plan:
- ADD, no hazards: I1stArg=0x0003, I2ndArg=0x0004, ALUOP=0, IRd=5, IRegWrite=1 -> next edge OALUResult=0x0007, ORd=5, ORegWrite=1, OZero=0, Stall=0.
- Forwarding priority: IRs1=2, MemFwdRd=2/MemFwdData=0x0010, WbFwdRd=2/WbFwdData=0x0020, both RegWrite=1, I2ndArg=1, ADD -> OALUResult=0x0011. Repeat with MemFwdRegWrite=0 -> 0x0021. Repeat with IRs1=0 -> uses I1stArg.
- MUL: A=0x0123, B=0x0045, ALUOP=7:
  - Stall high 16 consecutive cycles, low on the 17th.
  - EX/MEM shows bubbles throughout.
  - Then OALUResult=0x4E6F (0x0123*0x45=0x4E6F), controls restored.
  - The next ID/EX instruction completes 1 cycle later.
- MUL wrap: 0xFFFF*0xFFFF -> OALUResult=0x0001. 0x8000*0x0002 -> 0x0000 with OZero=1.
- Flush mid-MUL at cnt=7 -> Stall drops the same cycle, next edge all O*=0, FSM IDLE. A following ADD executes normally.
- Async Reset mid-MUL (asserted between edges) -> all O* = 0 immediately, Stall=0. After release, SRL 0x8000 by Imm=0x000F with IALUSrc=1 -> OALUResult=0x0001.
